// File: rtl/fsmc_pkg.sv
// Shared op encoding, state type and counter sizing for the FSMC-style bus master.
package fsmc_pkg;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_ADDR  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_READ  = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold
    } fsmc_state_e;

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/fsmc_phase_timer.sv
// Loadable down-counter shared by the SETUP, STROBE and HOLD phases.
// done_o flags the last cycle of a phase, near_done_o the cycle before it.
module fsmc_phase_timer #(
    parameter int unsigned Width = 3
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             done_o,
    output logic             near_done_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o      = (cnt_q == '0);
    assign near_done_o = (cnt_q == Width'(1));

endmodule

// File: rtl/fsmc_bus_master.sv
// FSMC-style parallel-bus initiator: one command becomes a SETUP/STROBE/HOLD strobe sequence.
// Optional FSMC_CE_KEEP_EN: accept the next command in the last HOLD cycle and keep nce low.
module fsmc_bus_master
    import fsmc_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 6,
    parameter int unsigned HOLD_CYC   = 2
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        nce,
    output logic        noe,
    output logic        nwe,
    output logic        ale,
    output logic        cle,
    output logic [15:0] data_o,
    output logic        data_oe,
    input  logic [15:0] data_i
);

`ifdef FSMC_CE_KEEP_EN
    localparam bit CeKeep = 1'b1;
`else
    localparam bit CeKeep = 1'b0;
`endif

    localparam int unsigned CntW = cnt_width(SETUP_CYC, STROBE_CYC, HOLD_CYC);
    localparam logic [CntW-1:0] SetupLd  = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] StrobeLd = CntW'(STROBE_CYC - 1);
    localparam logic [CntW-1:0] HoldLd   = CntW'(HOLD_CYC - 1);

    fsmc_state_e state_d, state_q;
    logic [1:0]  op_d, op_q;
    logic        cmd_ready_d, cmd_ready_q;
    logic        rsp_valid_d, rsp_valid_q;
    logic [15:0] rsp_data_d, rsp_data_q;
    logic        nce_d, nce_q;
    logic        noe_d, noe_q;
    logic        nwe_d, nwe_q;
    logic        ale_d, ale_q;
    logic [15:0] data_o_d, data_o_q;
    logic        data_oe_d, data_oe_q;

    logic            tmr_load;
    logic [CntW-1:0] tmr_val;
    logic            tmr_done;
    logic            tmr_near;
    logic            accept;
    logic            start;
    logic            finish;

    assign accept = cmd_valid && cmd_ready_q;

    fsmc_phase_timer #(
        .Width(CntW)
    ) u_timer (
        .clk        (clk),
        .reset_l    (reset_l),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done),
        .near_done_o(tmr_near)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        nce_d       = nce_q;
        noe_d       = noe_q;
        nwe_d       = nwe_q;
        ale_d       = ale_q;
        data_o_d    = data_o_q;
        data_oe_d   = data_oe_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        start       = 1'b0;
        finish      = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd_ready_d = 1'b1;
                if (accept && cmd_op != OP_NOP) start = 1'b1;
            end
            StSetup: begin
                if (tmr_done) begin
                    state_d  = StStrobe;
                    tmr_load = 1'b1;
                    tmr_val  = StrobeLd;
                    if (op_q == OP_READ) noe_d = 1'b0;
                    else                 nwe_d = 1'b0;
                end
            end
            StStrobe: begin
                if (tmr_done) begin
                    state_d  = StHold;
                    tmr_load = 1'b1;
                    tmr_val  = HoldLd;
                    noe_d    = 1'b1;
                    nwe_d    = 1'b1;
                    // Read data is sampled on the same edge that releases noe.
                    if (op_q == OP_READ) begin
                        rsp_data_d  = data_i;
                        rsp_valid_d = 1'b1;
                    end
                    if (CeKeep && HOLD_CYC == 1) cmd_ready_d = 1'b1;
                end
            end
            StHold: begin
                if (CeKeep && tmr_near) cmd_ready_d = 1'b1;
                if (tmr_done) begin
                    if (accept && cmd_op != OP_NOP) start = 1'b1;
                    else                            finish = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (finish) begin
            state_d     = StIdle;
            nce_d       = 1'b1;
            ale_d       = 1'b0;
            data_oe_d   = 1'b0;
            cmd_ready_d = 1'b1;
        end

        // A back-to-back start from HOLD keeps nce low: it is never raised on this path.
        if (start) begin
            state_d     = StSetup;
            op_d        = cmd_op;
            nce_d       = 1'b0;
            ale_d       = (cmd_op == OP_ADDR);
            data_o_d    = cmd_data;
            data_oe_d   = (cmd_op != OP_READ);
            cmd_ready_d = 1'b0;
            tmr_load    = 1'b1;
            tmr_val     = SetupLd;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= StIdle;
            op_q        <= OP_NOP;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            nce_q       <= 1'b1;
            noe_q       <= 1'b1;
            nwe_q       <= 1'b1;
            ale_q       <= 1'b0;
            data_o_q    <= '0;
            data_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            nce_q       <= nce_d;
            noe_q       <= noe_d;
            nwe_q       <= nwe_d;
            ale_q       <= ale_d;
            data_o_q    <= data_o_d;
            data_oe_q   <= data_oe_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign nce       = nce_q;
    assign noe       = noe_q;
    assign nwe       = nwe_q;
    assign ale       = ale_q;
    assign cle       = 1'b0;
    assign data_o    = data_o_q;
    assign data_oe   = data_oe_q;

endmodule

// File: tb/tb_fsmc_bus_master.sv
// Bench for fsmc_bus_master: three parameter sets, directed scenarios plus random commands,
// each checked every cycle against an offset-based transaction model. Honours FSMC_CE_KEEP_EN.
module tb_fsmc_bus_master;
    import fsmc_pkg::*;

`ifdef FSMC_CE_KEEP_EN
    localparam bit Keep = 1'b1;
`else
    localparam bit Keep = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int S = (g == 0) ? 2 : (g == 1) ? 1 : 3;
        localparam int T = (g == 0) ? 6 : (g == 1) ? 2 : 8;
        localparam int H = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        localparam int L = S + T + H;

        logic        reset_l, cmd_valid, cmd_ready, rsp_valid;
        logic        nce, noe, nwe, ale, cle, data_oe;
        logic [1:0]  cmd_op;
        logic [15:0] cmd_data, rsp_data, data_o, data_i;
        bit          fix_di = 1'b0;
        bit          done = 1'b0;
        int          cyc = 0;
        int          n_nwe_low = 0, n_nce_low = 0, n_nce_hi = 0, n_rv = 0, n_oe_hi = 0;

        fsmc_bus_master #(
            .SETUP_CYC (S),
            .STROBE_CYC(T),
            .HOLD_CYC  (H)
        ) u_dut (
            .clk      (clk),
            .reset_l  (reset_l),
            .cmd_valid(cmd_valid),
            .cmd_ready(cmd_ready),
            .cmd_op   (cmd_op),
            .cmd_data (cmd_data),
            .rsp_valid(rsp_valid),
            .rsp_data (rsp_data),
            .nce      (nce),
            .noe      (noe),
            .nwe      (nwe),
            .ale      (ale),
            .cle      (cle),
            .data_o   (data_o),
            .data_oe  (data_oe),
            .data_i   (data_i)
        );

        // Model: a transaction is an op plus an offset t = cycles since its accept edge.
        bit          m_busy, m_up, m_rv;
        int          m_t;
        logic [1:0]  m_op;
        logic [15:0] m_dout, m_rsp;
        logic        m_rdy;
        assign m_rdy = m_up && (!m_busy || (Keep && m_t == L));

        always @(posedge clk or negedge reset_l) begin
            if (!reset_l) begin
                m_busy <= 1'b0; m_up <= 1'b0; m_rv <= 1'b0; m_t <= 0;
                m_op <= OP_NOP; m_dout <= '0; m_rsp <= '0;
            end else begin
                m_up <= 1'b1;
                m_rv <= m_busy && m_op == OP_READ && m_t == S + T;
                if (m_busy && m_op == OP_READ && m_t == S + T) m_rsp <= data_i;
                if (m_busy && m_t < L) begin
                    m_t <= m_t + 1;
                end else if (m_rdy && cmd_valid && cmd_op != OP_NOP) begin
                    m_busy <= 1'b1; m_t <= 1; m_op <= cmd_op; m_dout <= cmd_data;
                end else begin
                    m_busy <= 1'b0;
                end
            end
        end

        always @(posedge clk) cyc <= cyc + 1;

        always @(negedge clk) begin
            automatic bit strobe = m_busy && m_t > S && m_t <= S + T;
            chk("nce", nce, !m_busy);
            chk("ale", ale, m_busy && m_op == OP_ADDR);
            chk("cle", cle, 1'b0);
            chk("data_oe", data_oe, m_busy && m_op != OP_READ);
            chk("data_o", data_o, m_dout);
            chk("nwe", nwe, !(strobe && m_op != OP_READ));
            chk("noe", noe, !(strobe && m_op == OP_READ));
            chk("cmd_ready", cmd_ready, m_rdy);
            chk("rsp_valid", rsp_valid, m_rv);
            chk("rsp_data", rsp_data, m_rsp);
            chk("strobe_excl", noe | nwe, 1'b1);
            chk("oe_vs_noe", data_oe & ~noe, 1'b0);
            if (!nwe) n_nwe_low++;
            if (!nce) n_nce_low++;
            if (nce) n_nce_hi++;
            if (rsp_valid) n_rv++;
            if (data_oe) n_oe_hi++;
        end

        initial begin
            forever begin
                @(posedge clk);
                #1;
                data_i = fix_di ? 16'hBEEF : 16'($urandom);
            end
        end

        task automatic send(input logic [1:0] op, input logic [15:0] d, output int acc,
                            output int waited);
            bit r, ok;
            ok = 1'b0;
            acc = 0;
            waited = 0;
            cmd_valid = 1'b1;
            cmd_op = op;
            cmd_data = d;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge clk);
                r = cmd_ready;
                @(posedge clk);
                waited++;
                if (r) begin
                    ok = 1'b1;
                    acc = cyc;
                end
            end
            #1;
            cmd_valid = 1'b0;
            cmd_op = 2'($urandom);
            cmd_data = 16'($urandom);
            if (!ok) begin
                n_chk++;
                $display("FAIL accept_timeout: inst %0d op %0d not accepted in 200 cycles", g, op);
            end
        endtask

        task automatic wait_idle();
            repeat (L + 2) @(posedge clk);
            #1;
        endtask

        initial begin
            int a0, a1, a2, a3, w, s0, s1, s2;
            reset_l = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = '0;
            #13;
            chk("rst_nce", nce, 1'b1);
            chk("rst_noe_nwe", {noe, nwe}, 2'b11);
            chk("rst_ale_oe", {ale, data_oe}, 2'b00);
            chk("rst_ready", cmd_ready, 1'b0);
            chk("rst_rsp", {rsp_valid, rsp_data}, 17'h0);
            #4 reset_l = 1'b1;
            @(posedge clk); #1;
            chk("ready_after_rst", cmd_ready, 1'b1);

            // ADDR 0x0005
            s0 = n_nwe_low; s1 = n_nce_low;
            send(OP_ADDR, 16'h0005, a0, w);
            @(negedge clk);
            chk("addr_data_o", data_o, 16'h0005);
            chk("addr_ale_oe", {ale, data_oe, nce}, 3'b110);
            wait_idle();
            chk("addr_nwe_len", n_nwe_low - s0, T);
            chk("addr_nce_len", n_nce_low - s1, L);

            // WRITE then READ of 0xBEEF
            send(OP_WRITE, 16'hBEEF, a0, w);
            wait_idle();
            fix_di = 1'b1;
            s0 = n_rv; s1 = n_oe_hi;
            send(OP_READ, 16'h1234, a0, w);
            wait_idle();
            fix_di = 1'b0;
            chk("read_data", rsp_data, 16'hBEEF);
            chk("read_pulses", n_rv - s0, 1);
            chk("read_oe_cycles", n_oe_hi - s1, 0);

            // Back-to-back with cmd_valid held
            send(OP_ADDR, 16'h0040, a0, w);
            s0 = n_nce_hi;
            send(OP_WRITE, 16'h1111, a1, w);
            send(OP_WRITE, 16'h2222, a2, w);
            send(OP_READ, 16'h0000, a3, w);
            chk("b2b_nce_gaps", n_nce_hi - s0, Keep ? 0 : 3);
            chk("b2b_space1", a1 - a0, Keep ? L : L + 1);
            chk("b2b_space2", a2 - a1, Keep ? L : L + 1);
            chk("b2b_space3", a3 - a2, Keep ? L : L + 1);
            wait_idle();

            // NOP
            s0 = n_nce_low; s1 = n_rv; s2 = n_oe_hi;
            send(OP_NOP, 16'hFFFF, a0, w);
            chk("nop_latency", w, 1);
            repeat (4) @(posedge clk);
            #1;
            chk("nop_bus_quiet", (n_nce_low - s0) + (n_oe_hi - s2), 0);
            chk("nop_no_rsp", n_rv - s1, 0);

            // Reset in the middle of a WRITE strobe
            s1 = n_rv;
            send(OP_WRITE, 16'hA5A5, a0, w);
            repeat (S + 1) @(posedge clk);
            #2;
            chk("pre_rst_nwe", nwe, 1'b0);
            reset_l = 1'b0;
            #1;
            chk("mid_rst_bus", {nwe, nce, data_oe}, 3'b110);
            @(posedge clk); #3;
            reset_l = 1'b1;
            @(posedge clk); #1;
            chk("post_rst_ready", cmd_ready, 1'b1);
            repeat (L) @(posedge clk);
            chk("post_rst_no_rsp", n_rv - s1, 0);

            // Random commands with random gaps
            for (int i = 0; i < 150; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                send(2'($urandom_range(0, 3)), 16'($urandom), a0, w);
            end
            wait_idle();
            done = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 60000; i++) begin
            @(posedge clk);
            if (g_inst[0].done && g_inst[1].done && g_inst[2].done) break;
        end
        if (!(g_inst[0].done && g_inst[1].done && g_inst[2].done)) begin
            n_chk++;
            $display("FAIL global_timeout: stimulus did not complete within 60000 cycles");
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
